// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package riscv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PC_INC = 4;

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory handshake, redirect input and decode-side instruction stream.
interface fetch_sequencer_if #(parameter int XLEN = 32) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst_code;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_code, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_code, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; head is read combinationally,
// so a word pushed at an edge is visible in the following cycle.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  input  logic          clear,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, issues credit-limited word fetches, buffers responses with their
// PCs and flushes in-flight fetches on control-flow redirects.
module fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = riscv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              DEPTH    = 4
) (
  input logic              clk,
  input logic              reset,
  fetch_sequencer_if.master bus
);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = OW + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   resp_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     out_next;
  logic [OW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] head;
  logic [CW-1:0]     credit;
  logic              pop, grant, rsp, redir, push;
  logic [XLEN-1:0]   target;

  assign pop    = bus.inst_valid & bus.inst_ready;
  // Outstanding fetches plus buffered words must never exceed DEPTH, so a
  // response always has a FIFO slot waiting for it.
  assign credit = CW'(outstanding) + CW'(fifo_count) - CW'(pop);

  assign bus.imem_req  = (state == FETCH) && (credit < CW'(DEPTH));
  assign bus.imem_addr = pc;

  assign grant  = bus.imem_req & bus.imem_gnt;
  assign rsp    = bus.imem_rvalid & (state != IDLE);
  assign redir  = bus.redirect_valid & (state != IDLE);
  assign target = bus.redirect_pc & ~XLEN'(3);
  assign push   = (state == FETCH) & bus.imem_rvalid & ~redir & (~fifo_full | pop);

  always_comb begin
    out_next = outstanding;
    case ({grant, rsp})
      2'b10:   out_next = outstanding + 1'b1;
      2'b01:   out_next = outstanding - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (redir) begin
            pc      <= target;
            resp_pc <= target;
            state   <= (out_next != '0) ? FLUSH : FETCH;
          end else begin
            if (grant)           pc      <= pc + XLEN'(PC_INC);
            if (bus.imem_rvalid) resp_pc <= resp_pc + XLEN'(PC_INC);
          end
        end
        FLUSH: begin
          // Responses still in flight belong to the abandoned path and are dropped.
          if (redir) begin
            pc      <= target;
            resp_pc <= target;
          end
          if (out_next == '0) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.W(2 * XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({resp_pc, bus.imem_rdata}),
    .pop   (pop & ~redir),
    .clear (redir),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.inst_valid = ~fifo_empty;
  assign bus.inst_pc    = head[2*XLEN-1:XLEN];
  assign bus.inst_code  = head[XLEN-1:0];
endmodule
